// File: rtl/wbq_pkg.sv
// rtl/wbq_pkg.sv - shared entry type and constants for the writeback queue
package wbq_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 64;

    // Writes to the zero register are architecturally discarded
    localparam logic [REG_W-1:0] XZR = 5'd31;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wbq_match.sv
// rtl/wbq_match.sv - youngest-match bypass lookup over age-ordered queue entries
module wbq_match
    import wbq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH*REG_W-1:0]  regs_i,
    input  logic [DEPTH*DATA_W-1:0] data_i,
    input  logic [DEPTH-1:0]        valid_i,
    input  logic [REG_W-1:0]        lookup_i,
    output logic                    hit_o,
    output logic [DATA_W-1:0]       data_o
);

    // Slot 0 is the oldest entry, so the last match in the scan is the youngest
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        if (lookup_i != XZR) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (valid_i[k] && (regs_i[k*REG_W +: REG_W] == lookup_i)) begin
                    hit_o  = 1'b1;
                    data_o = data_i[k*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - pending register-file write FIFO with load/ALU enqueue ports
// and a one-per-cycle drain; bypass lookup enabled by WBQ_BYPASS_EN.
module writeback_queue
    import wbq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ld_valid,
    input  logic [4:0]              ld_reg,
    input  logic [63:0]             ld_data,
    output logic                    ld_ready,
    input  logic                    alu_valid,
    input  logic [4:0]              alu_reg,
    input  logic [63:0]             alu_data,
    output logic                    alu_ready,
    output logic                    RegWrite,
    output logic [4:0]              WriteRegister,
    output logic [63:0]             WriteData,
    input  logic [4:0]              lookup_reg1,
    input  logic [4:0]              lookup_reg2,
    output logic                    hit1,
    output logic                    hit2,
    output logic [63:0]             fwd_data1,
    output logic [63:0]             fwd_data2,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t        mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic             ld_push;
    logic             alu_push;
    logic             pop;
    logic [PW-1:0]    alu_slot;
    wb_entry_t        head_entry;

    // Readiness uses registered occupancy only; the load port owns the last free slot
    assign ld_ready  = (count_q < CW'(DEPTH));
    assign alu_ready = (count_q <= CW'(DEPTH - 2)) |
                       ((count_q == CW'(DEPTH - 1)) & ~ld_valid);

    assign ld_push  = ld_valid & ld_ready & (ld_reg != XZR);
    assign alu_push = alu_valid & alu_ready & (alu_reg != XZR);
    assign pop      = (count_q != '0);

    // Load is older than a same-cycle ALU result, so ALU lands one slot later
    assign alu_slot = tail_q + PW'(ld_push);

    always_comb begin
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q + PW'(ld_push) + PW'(alu_push);
        count_d = count_q + CW'(ld_push) + CW'(alu_push) - CW'(pop);
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        if (ld_push) begin
            valid_d[tail_q] = 1'b1;
        end
        if (alu_push) begin
            valid_d[alu_slot] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_push) begin
            mem_q[tail_q] <= '{rd: ld_reg, data: ld_data};
        end
        if (alu_push) begin
            mem_q[alu_slot] <= '{rd: alu_reg, data: alu_data};
        end
    end

    assign head_entry    = mem_q[head_q];
    assign RegWrite      = pop;
    assign WriteRegister = pop ? head_entry.rd   : '0;
    assign WriteData     = pop ? head_entry.data : '0;
    assign count         = count_q;

`ifdef WBQ_BYPASS_EN
    logic [DEPTH*REG_W-1:0]  ord_regs;
    logic [DEPTH*DATA_W-1:0] ord_data;
    logic [DEPTH-1:0]        ord_valid;

    // Rotate storage so slot 0 is the head; the head stays visible while draining
    always_comb begin
        ord_regs  = '0;
        ord_data  = '0;
        ord_valid = '0;
        for (int k = 0; k < DEPTH; k++) begin
            ord_regs[k*REG_W +: REG_W]   = mem_q[head_q + PW'(k)].rd;
            ord_data[k*DATA_W +: DATA_W] = mem_q[head_q + PW'(k)].data;
            ord_valid[k]                 = valid_q[head_q + PW'(k)];
        end
    end

    wbq_match #(.DEPTH(DEPTH)) u_match1 (
        .regs_i   (ord_regs),
        .data_i   (ord_data),
        .valid_i  (ord_valid),
        .lookup_i (lookup_reg1),
        .hit_o    (hit1),
        .data_o   (fwd_data1)
    );

    wbq_match #(.DEPTH(DEPTH)) u_match2 (
        .regs_i   (ord_regs),
        .data_i   (ord_data),
        .valid_i  (ord_valid),
        .lookup_i (lookup_reg2),
        .hit_o    (hit2),
        .data_o   (fwd_data2)
    );
`else
    logic unused_lookup;

    assign unused_lookup = ^{lookup_reg1, lookup_reg2};
    assign hit1          = 1'b0;
    assign hit2          = 1'b0;
    assign fwd_data1     = '0;
    assign fwd_data2     = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - scoreboard bench for writeback_queue
module tb_writeback_queue;

    localparam int DEPTH = 4;

`ifdef WBQ_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    ld_valid = 1'b0;
    logic [4:0]              ld_reg = '0;
    logic [63:0]             ld_data = '0;
    logic                    ld_ready;
    logic                    alu_valid = 1'b0;
    logic [4:0]              alu_reg = '0;
    logic [63:0]             alu_data = '0;
    logic                    alu_ready;
    logic                    RegWrite;
    logic [4:0]              WriteRegister;
    logic [63:0]             WriteData;
    logic [4:0]              lookup_reg1 = '0;
    logic [4:0]              lookup_reg2 = '0;
    logic                    hit1;
    logic                    hit2;
    logic [63:0]             fwd_data1;
    logic [63:0]             fwd_data2;
    logic [$clog2(DEPTH):0]  count;

    int          passed = 0;
    int          total  = 0;
    logic [68:0] exp_q[$];
    logic [68:0] mon_e;

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .ld_valid      (ld_valid),
        .ld_reg        (ld_reg),
        .ld_data       (ld_data),
        .ld_ready      (ld_ready),
        .alu_valid     (alu_valid),
        .alu_reg       (alu_reg),
        .alu_data      (alu_data),
        .alu_ready     (alu_ready),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .lookup_reg1   (lookup_reg1),
        .lookup_reg2   (lookup_reg2),
        .hit1          (hit1),
        .hit2          (hit2),
        .fwd_data1     (fwd_data1),
        .fwd_data2     (fwd_data2),
        .count         (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [4:0] r, input logic [63:0] d);
        exp_q.push_back({r, d});
    endtask

    task automatic drive_ld(input logic [4:0] r, input logic [63:0] d);
        ld_valid = 1'b1;
        ld_reg   = r;
        ld_data  = d;
    endtask

    task automatic drive_alu(input logic [4:0] r, input logic [63:0] d);
        alu_valid = 1'b1;
        alu_reg   = r;
        alu_data  = d;
    endtask

    task automatic idle_inputs();
        ld_valid  = 1'b0;
        alu_valid = 1'b0;
    endtask

    // Monitor: every register-file write must match the oldest expected entry
    always @(negedge clk) begin
        if (reset) begin
            if (RegWrite) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_write: got reg %0d data 0x%0h, expected no write",
                             WriteRegister, WriteData);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("write_reg", 64'(WriteRegister), 64'(mon_e[68:64]));
                    check("write_data", WriteData, mon_e[63:0]);
                end
            end else begin
                check("idle_wreg", 64'(WriteRegister), 64'd0);
                check("idle_wdata", WriteData, 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1);
    end

    initial begin
        #12;
        check("rst_regwrite", 64'(RegWrite), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_hit1", 64'(hit1), 64'd0);
        check("rst_hit2", 64'(hit2), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_rst_ld_ready", 64'(ld_ready), 64'd1);
        check("post_rst_alu_ready", 64'(alu_ready), 64'd1);

        // Dual push: load older than ALU, drained on consecutive cycles
        tick();
        drive_ld(5'd3, 64'hAA);
        drive_alu(5'd4, 64'hBB);
        push_exp(5'd3, 64'hAA);
        push_exp(5'd4, 64'hBB);
        tick();
        idle_inputs();
        @(negedge clk);
        check("s1_count2", 64'(count), 64'd2);
        check("s1_latency", 64'(RegWrite), 64'd1);
        @(negedge clk);
        check("s1_count1", 64'(count), 64'd1);
        @(negedge clk);
        check("s1_count0", 64'(count), 64'd0);

        // XZR is accepted but never enqueued
        tick();
        drive_alu(5'd31, 64'hDEAD);
        @(negedge clk);
        check("s2_alu_ready", 64'(alu_ready), 64'd1);
        tick();
        idle_inputs();
        @(negedge clk);
        check("s2_count", 64'(count), 64'd0);
        check("s2_regwrite", 64'(RegWrite), 64'd0);

        // Fill toward full: last free slot goes to the load port
        tick();
        drive_ld(5'd10, 64'h10);
        drive_alu(5'd11, 64'h11);
        push_exp(5'd10, 64'h10);
        push_exp(5'd11, 64'h11);
        tick();
        drive_ld(5'd12, 64'h12);
        drive_alu(5'd13, 64'h13);
        push_exp(5'd12, 64'h12);
        push_exp(5'd13, 64'h13);
        @(negedge clk);
        check("s3_count2", 64'(count), 64'd2);
        check("s3_alu_ready_c2", 64'(alu_ready), 64'd1);
        tick();
        drive_ld(5'd14, 64'h14);
        drive_alu(5'd15, 64'h15);
        push_exp(5'd14, 64'h14);
        @(negedge clk);
        check("s3_count3", 64'(count), 64'd3);
        check("s3_ld_ready_c3", 64'(ld_ready), 64'd1);
        check("s3_alu_ready_c3", 64'(alu_ready), 64'd0);
        tick();
        idle_inputs();
        @(negedge clk);
        check("s3_count_hold", 64'(count), 64'd3);
        check("s3_alu_ready_no_ld", 64'(alu_ready), 64'd1);
        repeat (3) @(negedge clk);
        check("s3_drained", 64'(count), 64'd0);

        // Bypass: two pending writes to r7, youngest wins, head still visible
        lookup_reg1 = 5'd7;
        lookup_reg2 = 5'd3;
        tick();
        drive_ld(5'd7, 64'h1);
        drive_alu(5'd7, 64'h2);
        push_exp(5'd7, 64'h1);
        push_exp(5'd7, 64'h2);
        @(negedge clk);
        check("s4_hit1_empty", 64'(hit1), 64'd0);
        tick();
        idle_inputs();
        @(negedge clk);
        check("s4_count2", 64'(count), 64'd2);
        check("s4_hit1", 64'(hit1), 64'(BYP));
        check("s4_fwd1_youngest", fwd_data1, BYP ? 64'h2 : 64'h0);
        check("s4_hit2_miss", 64'(hit2), 64'd0);
        check("s4_fwd2_miss", fwd_data2, 64'd0);
        @(negedge clk);
        check("s4_hit1_head", 64'(hit1), 64'(BYP));
        check("s4_fwd1_head", fwd_data1, BYP ? 64'h2 : 64'h0);
        @(negedge clk);
        check("s4_hit1_gone", 64'(hit1), 64'd0);
        check("s4_fwd1_gone", fwd_data1, 64'd0);

        // Reset mid-operation with three pending entries
        lookup_reg1 = 5'd22;
        tick();
        drive_ld(5'd20, 64'h20);
        drive_alu(5'd21, 64'h21);
        push_exp(5'd20, 64'h20);
        push_exp(5'd21, 64'h21);
        tick();
        drive_ld(5'd22, 64'h22);
        drive_alu(5'd23, 64'h23);
        push_exp(5'd22, 64'h22);
        push_exp(5'd23, 64'h23);
        tick();
        idle_inputs();
        @(negedge clk);
        check("s5_count3", 64'(count), 64'd3);
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("s5_rst_regwrite", 64'(RegWrite), 64'd0);
        check("s5_rst_count", 64'(count), 64'd0);
        check("s5_rst_hit1", 64'(hit1), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("s5_ld_ready", 64'(ld_ready), 64'd1);
        check("s5_alu_ready", 64'(alu_ready), 64'd1);
        repeat (4) @(negedge clk);
        check("s5_no_stale", 64'(count), 64'd0);

        // Sustained one push per cycle: occupancy steady at 1, pointers wrap
        for (int i = 0; i < 20; i++) begin
            tick();
            idle_inputs();
            if (i % 2 == 0) drive_ld(5'(i + 1), 64'h1000 + 64'(i));
            else            drive_alu(5'(i + 1), 64'h1000 + 64'(i));
            push_exp(5'(i + 1), 64'h1000 + 64'(i));
            @(negedge clk);
            if (i > 0) check("s6_count", 64'(count), 64'd1);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        check("s6_count_last", 64'(count), 64'd1);
        @(negedge clk);
        check("s6_count_end", 64'(count), 64'd0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
